// File: rtl/sprite_regs_pkg.sv
// Shared register map and score operation encoding for the sprite register bank.
package sprite_regs_pkg;
  localparam logic [6:0] LOCK       = 7'h60;
  localparam logic [6:0] SCORE      = 7'h61;
  localparam logic [6:0] SCORE_DISP = 7'h62;
  localparam logic [6:0] SCORE_ADD  = 7'h63;
  localparam logic [6:0] EXT_BASE   = 7'h70;
  localparam int SPRITE_STRIDE = 8;
  localparam int LOCK_W        = 8;

  typedef enum logic [1:0] {
    SCORE_HOLD,
    SCORE_LOAD,
    SCORE_ACCUM
  } score_op_e;
endpackage

// File: rtl/score_unit.sv
// Score register with saturating add, plus a displayed score that rolls
// one step toward the real score on every frame commit.
module score_unit
  import sprite_regs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  score_op_e   op,
  input  logic        disp_load,
  input  logic        step,
  input  logic [15:0] wdata,
  output logic [15:0] score,
  output logic [15:0] score_disp
);

  logic [16:0] sum;

  assign sum = {1'b0, score} + {1'b0, wdata};

  // A CPU load of score_disp takes priority over the roll-up step.
  always_ff @(posedge clk) begin
    if (reset) begin
      score      <= '0;
      score_disp <= '0;
    end else begin
      case (op)
        SCORE_LOAD:  score <= wdata;
        SCORE_ACCUM: score <= sum[16] ? 16'hFFFF : sum[15:0];
        default:     ;
      endcase
      if (disp_load) begin
        score_disp <= wdata;
      end else if (step) begin
        if (score_disp < score) begin
          score_disp <= score_disp + 16'd1;
        end else if (score_disp > score) begin
          score_disp <= score_disp - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_reg_bank.sv
// CPU-visible sprite register bank with a working copy and a display shadow copy
// that is refreshed atomically once per frame unless the CPU holds LOCK[0].
module sprite_reg_bank
  import sprite_regs_pkg::*;
#(
  parameter int NUM_SPRITES = 5,
  parameter int FIELDS      = 6,
  parameter int DATA_W      = 8,
  parameter int NUM_EXT     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [6:0]                             addr,
  input  logic [15:0]                            wdata,
  input  logic                                   we,
  input  logic                                   re,
  output logic [15:0]                            rdata,
  output logic                                   rvalid,
  input  logic                                   vblank,
  input  logic [$clog2(NUM_SPRITES*8)-1:0]       disp_sel,
  output logic [DATA_W-1:0]                      disp_data,
  output logic [15:0]                            score_disp,
  output logic                                   commit_done,
  input  logic [NUM_EXT*16-1:0]                  ext_in
);

  logic [DATA_W-1:0] working [NUM_SPRITES][FIELDS];
  logic [DATA_W-1:0] shadow  [NUM_SPRITES][FIELDS];
  logic [LOCK_W-1:0] lock;
  logic              commit_pending;
  logic              commit;
  logic [15:0]       score;
  logic [15:0]       rd_value;
  logic [DATA_W-1:0] disp_value;
  score_op_e         score_op;

  assign commit = commit_pending & ~lock[0];

  always_comb begin
    score_op = SCORE_HOLD;
    if (we && addr == SCORE) begin
      score_op = SCORE_LOAD;
    end else if (we && addr == SCORE_ADD) begin
      score_op = SCORE_ACCUM;
    end
  end

  score_unit u_score (
    .clk        (clk),
    .reset      (reset),
    .op         (score_op),
    .disp_load  (we && addr == SCORE_DISP),
    .step       (commit),
    .wdata      (wdata),
    .score      (score),
    .score_disp (score_disp)
  );

  // The shadow captures the pre-write working value when a write lands in the commit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        for (int f = 0; f < FIELDS; f++) begin
          working[s][f] <= '0;
          shadow[s][f]  <= '0;
        end
      end
      lock           <= '0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        for (int f = 0; f < FIELDS; f++) begin
          if (commit) begin
            shadow[s][f] <= working[s][f];
          end
          if (we && int'(addr) == s * SPRITE_STRIDE + f) begin
            working[s][f] <= wdata[DATA_W-1:0];
          end
        end
      end
      if (we && addr == LOCK) begin
        lock <= wdata[LOCK_W-1:0];
      end
      commit_pending <= commit ? 1'b0 : (commit_pending | vblank);
      commit_done    <= commit;
    end
  end

  always_comb begin
    rd_value = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      for (int f = 0; f < FIELDS; f++) begin
        if (int'(addr) == s * SPRITE_STRIDE + f) begin
          rd_value = 16'(working[s][f]);
        end
      end
    end
    if (addr == LOCK)       rd_value = 16'(lock);
    if (addr == SCORE)      rd_value = score;
    if (addr == SCORE_DISP) rd_value = score_disp;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (int'(addr) == int'(EXT_BASE) + i) begin
        rd_value = ext_in[i*16 +: 16];
      end
    end
  end

  always_comb begin
    disp_value = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      for (int f = 0; f < FIELDS; f++) begin
        if (int'(disp_sel) == s * SPRITE_STRIDE + f) begin
          disp_value = shadow[s][f];
        end
      end
    end
  end

  // rdata keeps its last value between reads; only rvalid marks a fresh result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      disp_data <= '0;
    end else begin
      rvalid    <= re;
      if (re) begin
        rdata <= rd_value;
      end
      disp_data <= disp_value;
    end
  end

endmodule
